// File: rtl/poly_horner_seq.sv
// poly_horner_seq: sequential Horner polynomial evaluator, one time-shared MAC per clock.
// Coefficients are read from an external combinational ROM addressed by coef_addr.
module poly_horner_seq #(
    parameter int DATA_WIDTH   = 16,
    parameter int I_WIDTH_X    = 2,
    parameter int I_WIDTH_COEF = 7,
    parameter int I_WIDTH_OUT  = 2,
    parameter int ORDER        = 3,
    parameter int ROUND_EN     = 1,
    parameter int SAT_EN       = 1,
    parameter int AW           = $clog2(ORDER + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic [AW-1:0]         coef_addr,
    input  logic [DATA_WIDTH-1:0] coef_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] p_out,
    output logic                  sat_flag
);

    localparam int F_X       = DATA_WIDTH - I_WIDTH_X;
    localparam int OUT_SHIFT = I_WIDTH_COEF - I_WIDTH_OUT;
    localparam int PW        = 2 * DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_MAC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] MAX_EXT = $signed({{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [PW-1:0] MIN_EXT = $signed({{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});
    localparam logic signed [PW-1:0] RND_BIAS = (ROUND_EN != 0) ? (PW'(1) << (F_X - 1)) : PW'(0);

    function automatic logic ovf(input logic signed [PW-1:0] v);
        return (v > MAX_EXT) || (v < MIN_EXT);
    endfunction

    // Out-of-range values clamp when saturating, otherwise keep the low bits (wrap).
    function automatic logic [DATA_WIDTH-1:0] clip(input logic signed [PW-1:0] v);
        if (SAT_EN != 0 && v > MAX_EXT) return MAX_V;
        if (SAT_EN != 0 && v < MIN_EXT) return MIN_V;
        return v[DATA_WIDTH-1:0];
    endfunction

    logic [1:0]            state_q, state_d;
    logic [AW-1:0]         k_q, k_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  sticky_q, sticky_d;
    logic [DATA_WIDTH-1:0] p_out_q, p_out_d;
    logic                  flag_q, flag_d;

    logic signed [PW-1:0]  x_ext, acc_ext, coef_ext, prod, prod_sh;
    logic signed [PW-1:0]  prod_red_ext, sum_full, sum_red_ext, out_full;
    logic [DATA_WIDTH-1:0] prod_red, sum_red, out_red;
    logic                  prod_ovf, sum_ovf, out_ovf;
    logic                  accept;

    assign x_ext    = $signed({{DATA_WIDTH{x_q[DATA_WIDTH-1]}}, x_q});
    assign acc_ext  = $signed({{DATA_WIDTH{acc_q[DATA_WIDTH-1]}}, acc_q});
    assign coef_ext = $signed({{DATA_WIDTH{coef_data[DATA_WIDTH-1]}}, coef_data});

    assign prod         = x_ext * acc_ext;
    assign prod_sh      = (prod + RND_BIAS) >>> F_X;
    assign prod_ovf     = ovf(prod_sh);
    assign prod_red     = clip(prod_sh);
    assign prod_red_ext = $signed({{DATA_WIDTH{prod_red[DATA_WIDTH-1]}}, prod_red});
    assign sum_full     = prod_red_ext + coef_ext;
    assign sum_ovf      = ovf(sum_full);
    assign sum_red      = clip(sum_full);
    assign sum_red_ext  = $signed({{DATA_WIDTH{sum_red[DATA_WIDTH-1]}}, sum_red});
    assign out_full     = sum_red_ext <<< OUT_SHIFT;
    assign out_ovf      = ovf(out_full);
    assign out_red      = clip(out_full);

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign p_out     = p_out_q;
    assign sat_flag  = flag_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        k_d       = k_q;
        x_d       = x_q;
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        p_out_d   = p_out_q;
        flag_d    = flag_q;
        coef_addr = AW'(ORDER);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    x_d      = x_in;
                    sticky_d = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_d   = coef_data;
                k_d     = AW'(ORDER - 1);
                state_d = S_MAC;
            end
            S_MAC: begin
                coef_addr = k_q;
                acc_d     = sum_red;
                sticky_d  = sticky_q | prod_ovf | sum_ovf;
                if (k_q == '0) begin
                    p_out_d = out_red;
                    flag_d  = sticky_q | prod_ovf | sum_ovf | out_ovf;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q - AW'(1);
                end
            end
            default: begin
                if (out_ready) begin
                    if (in_valid) begin
                        x_d      = x_in;
                        sticky_d = 1'b0;
                        state_d  = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            x_q      <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            p_out_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            p_out_q  <= p_out_d;
            flag_q   <= flag_d;
        end
    end

endmodule

// File: tb/tb_poly_horner_seq.sv
// Directed and randomised checks of poly_horner_seq: default build, a wrap/truncate
// build and an ORDER=1 build, all sharing one coefficient table.
module tb_poly_horner_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       in_valid, in_ready, out_valid, out_ready, sat_flag;
    logic [2:0][15:0] x_in, coef_data, p_out;
    logic [1:0]       addr0, addr1;
    logic [0:0]       addr2;
    logic [15:0]      coef [4];

    int n_pass  = 0;
    int n_total = 0;

    assign coef_data[0] = coef[addr0];
    assign coef_data[1] = coef[addr1];
    assign coef_data[2] = coef[{1'b0, addr2}];

    poly_horner_seq #(.ORDER(3)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .x_in(x_in[0]),
        .coef_addr(addr0), .coef_data(coef_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .p_out(p_out[0]), .sat_flag(sat_flag[0])
    );

    poly_horner_seq #(.ORDER(3), .ROUND_EN(0), .SAT_EN(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .x_in(x_in[1]),
        .coef_addr(addr1), .coef_data(coef_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .p_out(p_out[1]), .sat_flag(sat_flag[1])
    );

    poly_horner_seq #(.ORDER(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .x_in(x_in[2]),
        .coef_addr(addr2), .coef_data(coef_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .p_out(p_out[2]), .sat_flag(sat_flag[2])
    );

    typedef struct {
        int          dut;
        logic [15:0] c0, c1, c2, c3;
        logic [15:0] x;
        logic [15:0] exp_p;
        logic        exp_f;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_coef(input logic [15:0] c0, c1, c2, c3);
        coef[0] = c0; coef[1] = c1; coef[2] = c2; coef[3] = c3;
    endtask

    // Latency counts the accept edge as clock 1 up to the edge that raises out_valid.
    task automatic wait_valid(input int d, output int lat);
        lat = 1;
        while (out_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_sample(input int d, input logic [15:0] x,
                              output logic [15:0] p, output logic f, output int lat);
        @(negedge clk);
        in_valid[d]  = 1'b1;
        x_in[d]      = x;
        out_ready[d] = 1'b0;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        x_in[d]     = 16'hDEAD;
        wait_valid(d, lat);
        p = p_out[d];
        f = sat_flag[d];
        @(negedge clk);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    function automatic longint sx(input logic [15:0] a);
        logic signed [15:0] s;
        s = a;
        return longint'(s);
    endfunction

    function automatic longint lim(input longint v, input bit sat, inout bit f);
        logic signed [15:0] t;
        if (v > 32767 || v < -32768) begin
            f = 1'b1;
            if (sat) return (v > 0) ? 64'sd32767 : -64'sd32768;
        end
        t = v[15:0];
        return longint'(t);
    endfunction

    // Bit-accurate reference for Q2.14 x, Q7.9 coefficients/accumulator, Q2.14 output.
    function automatic void model(input int order, input bit rnd, input bit sat,
                                  input logic [15:0] x, output logic [15:0] p, output bit f);
        longint acc, v;
        f   = 1'b0;
        acc = sx(coef[order]);
        for (int k = order - 1; k >= 0; k--) begin
            v = sx(x) * acc;
            if (rnd) v = v + 64'sd8192;
            v   = v >>> 14;
            v   = lim(v, sat, f);
            v   = v + sx(coef[k]);
            acc = lim(v, sat, f);
        end
        v = lim(acc * 32, sat, f);
        p = v[15:0];
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return 16'($signed(r) >>> $urandom_range(0, 9));
    endfunction

    initial begin
        vec_t        vecs [9];
        int          lat, hold_err, order;
        logic [15:0] p, exp_p;
        logic        f;
        bit          exp_f;

        vecs[0] = '{0, 16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'h2000, 16'h4000, 1'b0, 5};
        vecs[1] = '{0, 16'h0600, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h7FFF, 1'b1, 5};
        vecs[2] = '{1, 16'h0600, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'hC000, 1'b1, 5};
        vecs[3] = '{0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h2000, 16'h0020, 1'b0, 5};
        vecs[4] = '{1, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h2000, 16'h0000, 1'b0, 5};
        vecs[5] = '{0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'hE000, 16'h0000, 1'b0, 5};
        vecs[6] = '{2, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'hC000, 16'hC000, 1'b0, 3};
        vecs[7] = '{0, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 5};
        vecs[8] = '{1, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 5};

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        x_in      = '0;
        set_coef(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_out_valid%0d", d), out_valid[d], 0);
            check($sformatf("rst_in_ready%0d", d), in_ready[d], 1);
            check($sformatf("rst_p_out%0d", d), p_out[d], 0);
            check($sformatf("rst_sat_flag%0d", d), sat_flag[d], 0);
        end
        check("rst_addr_a", addr0, 3);
        check("rst_addr_c", addr2, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            set_coef(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3);
            run_sample(vecs[i].dut, vecs[i].x, p, f, lat);
            check($sformatf("vec%0d_p_out", i), p, vecs[i].exp_p);
            check($sformatf("vec%0d_sat_flag", i), f, vecs[i].exp_f);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // Backpressure: result and flag held while out_ready stays low.
        set_coef(16'h0100, 16'h0200, 16'h0000, 16'h0000);
        @(negedge clk);
        in_valid[0] = 1'b1; x_in[0] = 16'h2000;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_valid(0, lat);
        check("bp_first_p_out", p_out[0], 16'h4000);
        hold_err = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (p_out[0] !== 16'h4000 || sat_flag[0] !== 1'b0 || in_ready[0] !== 1'b0 ||
                out_valid[0] !== 1'b1) hold_err++;
        end
        check("bp_hold_stable_cycles_bad", hold_err, 0);
        @(negedge clk);
        in_valid[0] = 1'b1; x_in[0] = 16'h4000; out_ready[0] = 1'b1;
        #1;
        check("bp_in_ready_comb", in_ready[0], 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        check("bp_out_valid_drop", out_valid[0], 0);
        wait_valid(0, lat);
        check("bp_b2b_latency", lat, 5);
        check("bp_b2b_p_out", p_out[0], 16'h6000);
        @(negedge clk); out_ready[0] = 1'b1;
        @(posedge clk); #1; out_ready[0] = 1'b0;

        // Reset while dut_a is in MAC with k=1.
        @(negedge clk);
        in_valid[0] = 1'b1; x_in[0] = 16'h2000;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_rst_addr_k1", addr0, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", out_valid[0], 0);
        check("mid_rst_in_ready", in_ready[0], 1);
        check("mid_rst_p_out", p_out[0], 0);
        check("mid_rst_addr", addr0, 3);
        @(negedge clk); rst = 1'b0;
        run_sample(0, 16'h2000, p, f, lat);
        check("post_rst_p_out", p, 16'h4000);
        check("post_rst_latency", lat, 5);

        // Random sweep against the reference model on every build.
        for (int d = 0; d < 3; d++) begin
            order = (d == 2) ? 1 : 3;
            for (int i = 0; i < ((d == 2) ? 256 : 48); i++) begin
                logic [15:0] x;
                for (int j = 0; j < 4; j++) coef[j] = rnd16();
                x = 16'($urandom);
                model(order, d != 1, d != 1, x, exp_p, exp_f);
                run_sample(d, x, p, f, lat);
                check($sformatf("rand_d%0d_i%0d_p_out", d, i), p, exp_p);
                check($sformatf("rand_d%0d_i%0d_sat_flag", d, i), f, exp_f);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/poly_horner_seq.md
Name: poly_horner_seq

Overview:
Sequential, parametrised Horner-scheme polynomial evaluator for the DDS phase-to-amplitude path. It computes p(x) = c[ORDER]·x^ORDER + … + c[1]·x + c[0] in signed fixed point. One time-shared multiplier-accumulator performs one MAC per clock, and coefficients are fetched from an external combinational ROM. It replaces per-stage combinational MAC chains, adding configurable order, rounding, saturation with a flag, and valid/ready handshakes on both sides.

Parameters:
DATA_WIDTH, 16, word width of x, coefficients, accumulator and output.
I_WIDTH_X, 2, integer bits of x (signed, incl. sign); F_X = DATA_WIDTH-I_WIDTH_X.
I_WIDTH_COEF, 7, integer bits of coefficients and internal accumulator; F_C = DATA_WIDTH-I_WIDTH_COEF.
I_WIDTH_OUT, 2, integer bits of p_out; F_O = DATA_WIDTH-I_WIDTH_OUT; must be ≤ I_WIDTH_COEF.
ORDER, 3, polynomial order (≥1); ORDER+1 coefficients.
ROUND_EN, 1, 1 = round-half-up on product rescale; 0 = truncate (floor).
SAT_EN, 1, 1 = saturate on overflow; 0 = two's-complement wrap.
AW, $clog2(ORDER+1), coefficient address width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  x_in valid.
in_ready  out  1  block can accept x_in.
x_in  in  DATA_WIDTH  signed x, Q(I_WIDTH_X.F_X).
coef_addr  out  AW  coefficient index to ROM.
coef_data  in  DATA_WIDTH  signed c[coef_addr], Q(I_WIDTH_COEF.F_C), combinational same-cycle read.
out_valid  out  1  p_out valid.
out_ready  in  1  downstream accepts p_out.
p_out  out  DATA_WIDTH  signed result, Q(I_WIDTH_OUT.F_O).
sat_flag  out  1  overflow occurred during this result (valid with out_valid).

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high. During and after reset: state = IDLE, out_valid = 0, p_out = 0, sat_flag = 0, accumulator = 0, k = 0.
- FSM states: IDLE, LOAD, MAC, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). The out_ready→in_ready combinational path is intentional.
- IDLE: coef_addr = ORDER. On in_valid&in_ready: register x_in, clear the sticky sat bit, go to LOAD.
- LOAD: coef_addr = ORDER; acc <= coef_data; k <= ORDER-1; go to MAC.
- MAC: coef_addr = k.
  - prod = x_reg·acc (2·DATA_WIDTH signed, F_X+F_C fractional bits).
  - Rescale: if ROUND_EN, add 2^(F_X-1); then arithmetic shift right F_X.
  - Reduce to DATA_WIDTH: saturate (SAT_EN=1) or wrap.
  - Sum = rescaled + coef_data at DATA_WIDTH+1 bits; reduce to DATA_WIDTH the same way.
  - acc <= sum.
  - If k==0, go to DONE and register p_out; else k <= k-1.
- p_out conversion: acc shifted left by (I_WIDTH_COEF-I_WIDTH_OUT), saturated to 0x7FFF…/0x8000… when SAT_EN, wrapped otherwise.
- sat_flag = OR of every overflow event (product reduce, sum reduce, output conversion) for the sample. It is set regardless of SAT_EN, so it reports wraps too.
- DONE: out_valid = 1; p_out and sat_flag held stable until out_ready.
  - out_ready & in_valid: accept new x, go to LOAD (back-to-back).
  - out_ready & !in_valid: go to IDLE.
  - out_valid drops the cycle after the handshake.
- Latency: the accept edge to first out_valid cycle is ORDER+2 clocks. Sustained throughput is one result per ORDER+2 clocks with out_ready held high.
- x_in, coef_data are sampled only in the states above; changes elsewhere are ignored.
- Reset mid-operation (any state): the in-flight sample is discarded; the next cycle shows IDLE with reset values.
- Most-negative operands (0x8000·0x8000) must follow the saturation/wrap rule, with sat_flag set on overflow.

Test Plan:
1. DATA_WIDTH=16, I_WIDTH_X=2, I_WIDTH_COEF=7, I_WIDTH_OUT=2, ORDER=3. c3=0, c2=0, c1=0x0200 (1.0), c0=0x0100 (0.5), x=0x2000 (0.5) → p_out=0x4000 (1.0), sat_flag=0, out_valid exactly 5 clocks after accept.
2. c0=0x0600 (3.0), others 0, any x → SAT_EN=1: p_out=0x7FFF, sat_flag=1. SAT_EN=0: p_out=0xC000, sat_flag=1.
3. c1=0x0001, others 0, x=0x2000 → ROUND_EN=1: p_out=0x0020. ROUND_EN=0: p_out=0x0000. x=0xE000 (-0.5) with ROUND_EN=1 → p_out=0x0000.
4. Hold out_ready=0 for 10 cycles after out_valid → p_out and sat_flag stable, in_ready=0. Then out_ready=1 with in_valid=1 → next sample accepted the same cycle, next out_valid 5 clocks later.
5. Assert rst for 1 cycle during MAC (k=1) → next cycle out_valid=0, in_ready=1, p_out=0, coef_addr=3. A fresh sample then yields the correct result.
6. ORDER=1, c1=0x0200, c0=0x0000, x=0xC000 (-1.0) → p_out=0xC000, latency 3 clocks; sweep 256 random x/coef sets against a bit-accurate reference model with zero mismatches.
